cw_trace_reader: RTL
====================

Name: cw_trace_reader

Overview:
- Read-side counterpart of the capture-buffer writer in the on-chip logic analyzer. The writer fills sample RAM through its wt_ce/wt_en/wt_addr port.
- After capture completes, this block walks the sample RAM from a start address with wrap-around. It fetches a programmed number of samples through a 1-cycle-latency read port.
- Samples are presented on a valid/ready word stream toward the JTAG status/readout shifter.

Parameters:
- DW, 4, sample width (bits per RAM word)
- AW, 16, RAM address width
- MEM_DEPTH, 5461, number of valid RAM words; addresses 0..MEM_DEPTH-1

Ports:
- clk  in  1  single clock
- rst  in  1  synchronous reset, active-high
- start  in  1  one-cycle pulse, begin readout
- abort  in  1  one-cycle pulse, cancel readout
- start_addr  in  AW  first sample address
- count  in  AW+1  samples to read (0..MEM_DEPTH)
- rd_ce  out  1  RAM read enable
- rd_addr  out  AW  RAM read address
- rd_data  in  DW  RAM data, valid exactly 1 cycle after rd_ce
- out_valid  out  1  stream word valid
- out_data  out  DW  sample
- out_last  out  1  final sample of the readout
- out_ready  in  1  consumer accepts
- busy  out  1  readout in progress
- done  out  1  one-cycle pulse at completion or abort
- err  out  1  sticky bad-parameter flag; cleared by next accepted start

Behaviour:
- Reset values: rd_ce=0, rd_addr=0, out_valid=0, out_data=0, out_last=0, busy=0, done=0, err=0. FSM is in IDLE.
- States: IDLE, FETCH, LAT, PRESENT, FINISH.
- IDLE:
  - start latches start_addr into addr and count into remaining. busy goes to 1 the next cycle.
  - If start_addr >= MEM_DEPTH or count > MEM_DEPTH: err=1, go to FINISH, no RAM reads.
  - If count == 0: go to FINISH with err=0.
  - Otherwise go to FETCH.
- FETCH: rd_ce=1 and rd_addr=addr for exactly one cycle, then go to LAT.
- LAT:
  - Capture rd_data into out_data.
  - Assert out_valid from the next cycle. out_last=1 if remaining==1.
  - Go to PRESENT.
- PRESENT:
  - Hold out_valid/out_data/out_last stable until out_ready.
  - On handshake: remaining decrements and addr advances as addr==MEM_DEPTH-1 ? 0 : addr+1. out_valid drops the same edge.
  - Next state is FETCH if remaining was >1, else FINISH.
- FINISH: done=1 for one cycle, busy=0, return to IDLE.
- Throughput is one sample per 3 cycles plus consumer stall. Start-to-first-out_valid latency is 3 cycles.
- start while busy is ignored. start and abort in the same IDLE cycle: abort wins, nothing is latched.
- abort in any non-IDLE state: out_valid, rd_ce and out_last drop on the next edge, then FINISH (done pulses) and IDLE. err is unchanged.
- An rd_data return in flight during abort is discarded.
- rst mid-readout returns to reset values on the next edge; no done pulse.
- Wrap: an address sequence crossing MEM_DEPTH-1 continues at 0, with no gap cycle.
- count==MEM_DEPTH reads every word exactly once.

Optional Feature:
- Macro CW_TRACE_READER_CRC_EN.
- When defined:
  - Adds output crc  out  16 and instantiates the CRC sub-module.
  - CRC-16-CCITT, polynomial 0x1021, init 0xFFFF, reloaded on accepted start.
  - Updated with each DW-bit sample MSB-first at its out handshake.
  - crc is stable from the done pulse until the next accepted start. On abort, crc holds its partial value.
- When undefined: no crc port and no CRC logic. All other timing is identical.

Decomposition:
- Package cw_trace_reader_pkg holds:
  - FSM state enum (IDLE, FETCH, LAT, PRESENT, FINISH)
  - CRC16_POLY=16'h1021, CRC16_INIT=16'hFFFF
  - default MEM_DEPTH constant shared with the writer side
- Sub-module cw_trace_reader_crc16: registered CRC, inputs clr/en/data[DW-1:0], output crc[15:0]. Only instantiated under the macro.

Test Plan:
- Basic readout:
  - Stimulus: RAM[i]=i[3:0]; start_addr=10, count=4, out_ready=1.
  - Required: rd_addr 10,11,12,13; out_data 0xA,0xB,0xC,0xD; out_last only on 0xD; done 1 cycle after the last handshake; err=0.
- Wrap-around:
  - Stimulus: start_addr=5459, count=4.
  - Required: rd_addr 5459,5460,0,1; out_last on the 4th word.
- Backpressure:
  - Stimulus: out_ready=0 for 7 cycles on the 2nd word.
  - Required: out_data/out_last stable and no new rd_ce while stalled; total 4 words, none duplicated or lost.
- Boundaries:
  - count=0: done pulse, no rd_ce, err=0.
  - start_addr=5461: err=1, no rd_ce.
  - count=5462: err=1.
  - Next valid start clears err.
- Abort and reset:
  - Abort in PRESENT of the 2nd of 8 words: out_valid low next cycle, one done pulse, busy 0 within 2 cycles, no further rd_ce.
  - rst asserted mid-LAT: all outputs at reset values next cycle, no done pulse.
- CRC (macro on):
  - Stimulus: count=MEM_DEPTH readout, plus a second readout of the same data.
  - Required: crc equals the bench model for the same sequence; identical crc on the repeated readout; crc reloaded to 0xFFFF at start.

Source files
------------

// File: rtl/cw_trace_reader_pkg.sv
// Shared types and constants for the trace-buffer readout path.
package cw_trace_reader_pkg;

  // Sample RAM depth shared with the capture-buffer writer.
  localparam int unsigned CW_MEM_DEPTH = 5461;

  localparam logic [15:0] CRC16_POLY = 16'h1021;
  localparam logic [15:0] CRC16_INIT = 16'hFFFF;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LAT,
    PRESENT,
    FINISH
  } state_t;

  // Advance a CRC-16-CCITT register by one input bit.
  function automatic logic [15:0] crc16_bit(logic [15:0] c, logic b);
    return {c[14:0], 1'b0} ^ ((c[15] ^ b) ? CRC16_POLY : 16'h0000);
  endfunction

endpackage

// File: rtl/cw_trace_reader_crc16.sv
// Registered CRC-16-CCITT over DW-bit words, MSB first.
module cw_trace_reader_crc16
  import cw_trace_reader_pkg::*;
#(
  parameter int unsigned DW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          en,
  input  logic [DW-1:0] data,
  output logic [15:0]   crc
);

  logic [15:0] crc_nxt;

  // Fold all DW bits of the word into the running CRC.
  always_comb begin
    logic [DW-1:0] d;
    crc_nxt = crc;
    d       = data;
    for (int unsigned i = 0; i < DW; i++) begin
      crc_nxt = crc16_bit(crc_nxt, d[DW-1]);
      d       = d << 1;
    end
  end

  // Reload on clear, otherwise accumulate on enable.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      crc <= CRC16_INIT;
    end else if (en) begin
      crc <= crc_nxt;
    end
  end

endmodule

// File: rtl/cw_trace_reader.sv
// Walks sample RAM from start_addr with wrap-around and streams count samples.
// Optional running CRC of the streamed samples: define CW_TRACE_READER_CRC_EN.
module cw_trace_reader
  import cw_trace_reader_pkg::*;
#(
  parameter int unsigned DW        = 4,
  parameter int unsigned AW        = 16,
  parameter int unsigned MEM_DEPTH = CW_MEM_DEPTH
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          abort,
  input  logic [AW-1:0] start_addr,
  input  logic [AW:0]   count,
  output logic          rd_ce,
  output logic [AW-1:0] rd_addr,
  input  logic [DW-1:0] rd_data,
  output logic          out_valid,
  output logic [DW-1:0] out_data,
  output logic          out_last,
  input  logic          out_ready,
  output logic          busy,
  output logic          done,
  output logic          err
`ifdef CW_TRACE_READER_CRC_EN
  ,
  output logic [15:0]   crc
`endif
);

  localparam logic [AW:0]   DEPTH_W   = (AW+1)'(MEM_DEPTH);
  localparam logic [AW-1:0] LAST_ADDR = AW'(MEM_DEPTH - 1);

  state_t        state, state_nxt;
  logic [AW-1:0] addr, addr_nxt;
  logic [AW:0]   remaining, rem_nxt;
  logic [AW-1:0] rd_addr_nxt;
  logic          out_valid_nxt, out_last_nxt, err_nxt;
  logic [DW-1:0] out_data_nxt;
  logic          rd_ce_nxt, busy_nxt, done_nxt;
  logic          bad_c, start_ok_c, hs_c;

  assign bad_c      = ({1'b0, start_addr} >= DEPTH_W) || (count > DEPTH_W);
  assign start_ok_c = (state == IDLE) && start && !abort;
  assign hs_c       = (state == PRESENT) && out_ready && !abort;

  // State register and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      addr      <= '0;
      remaining <= '0;
      rd_ce     <= 1'b0;
      rd_addr   <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      state     <= state_nxt;
      addr      <= addr_nxt;
      remaining <= rem_nxt;
      rd_ce     <= rd_ce_nxt;
      rd_addr   <= rd_addr_nxt;
      out_valid <= out_valid_nxt;
      out_data  <= out_data_nxt;
      out_last  <= out_last_nxt;
      busy      <= busy_nxt;
      done      <= done_nxt;
      err       <= err_nxt;
    end
  end

  // Next-state and next-output decode; abort outside IDLE overrides everything.
  always_comb begin
    state_nxt     = state;
    addr_nxt      = addr;
    rem_nxt       = remaining;
    rd_addr_nxt   = rd_addr;
    out_valid_nxt = out_valid;
    out_data_nxt  = out_data;
    out_last_nxt  = out_last;
    err_nxt       = err;

    if (abort && (state != IDLE)) begin
      state_nxt     = (state == FINISH) ? IDLE : FINISH;
      out_valid_nxt = 1'b0;
      out_last_nxt  = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start_ok_c) begin
            addr_nxt  = start_addr;
            rem_nxt   = count;
            err_nxt   = bad_c;
            state_nxt = (bad_c || (count == '0)) ? FINISH : FETCH;
          end
        end
        FETCH: state_nxt = LAT;
        LAT: begin
          out_data_nxt  = rd_data;
          out_valid_nxt = 1'b1;
          out_last_nxt  = (remaining == (AW+1)'(1));
          state_nxt     = PRESENT;
        end
        PRESENT: begin
          if (hs_c) begin
            out_valid_nxt = 1'b0;
            out_last_nxt  = 1'b0;
            rem_nxt       = remaining - (AW+1)'(1);
            addr_nxt      = (addr == LAST_ADDR) ? '0 : addr + AW'(1);
            state_nxt     = (remaining > (AW+1)'(1)) ? FETCH : FINISH;
          end
        end
        FINISH:  state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end

    if (state_nxt == FETCH) begin
      rd_addr_nxt = addr_nxt;
    end
  end

  assign rd_ce_nxt = (state_nxt == FETCH);
  assign done_nxt  = (state_nxt == FINISH);
  assign busy_nxt  = (state_nxt == FETCH) || (state_nxt == LAT) || (state_nxt == PRESENT);

`ifdef CW_TRACE_READER_CRC_EN
  cw_trace_reader_crc16 #(.DW(DW)) u_crc (
    .clk  (clk),
    .rst  (rst),
    .clr  (start_ok_c),
    .en   (hs_c),
    .data (out_data),
    .crc  (crc)
  );
`endif

endmodule
